// File: rtl/network_run_scheduler_pkg.sv
// Shared types and defaults for the network run scheduler.
// Optional statistics outputs are enabled with the RUN_STATS_EN macro.
package scheduler_config;

  localparam int RUN_WIDTH_DEF    = 16;
  localparam int MAX_INFLIGHT_DEF = 2;
  localparam int INFLIGHT_WIDTH   = $clog2(MAX_INFLIGHT_DEF + 1);

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_RUN  = 2'd1,
    OP_CLR  = 2'd2,
    OP_SYNC = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STEP      = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_SYNC_WAIT = 3'd3,
    ST_SYNC_SEND = 3'd4
  } state_t;

  // Counter width able to hold 0..max_inflight inclusive.
  function automatic int inflight_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/network_run_scheduler_if.sv
// Command, network-step, sink-accept and sync-token signals of the scheduler.
// master = host/network/sink side, slave = scheduler side.
interface network_run_scheduler_if #(
  parameter int RUN_WIDTH = scheduler_config::RUN_WIDTH_DEF
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [RUN_WIDTH-1:0] cmd_arg;
  logic                 net_step_valid;
  logic                 net_step_ready;
  logic                 net_clear;
  logic                 out_accept;
  logic                 sync_valid;
  logic                 sync_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, net_step_ready, out_accept, sync_ready,
    input  cmd_ready, net_step_valid, net_clear, sync_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, net_step_ready, out_accept, sync_ready,
    output cmd_ready, net_step_valid, net_clear, sync_valid
  );

endinterface

// File: rtl/network_run_scheduler_inflight_tracker.sv
// Up/down count of issued steps not yet accepted by the sink, with sticky underflow error.
// With RUN_STATS_EN the high-water mark of the count is also kept.
module inflight_tracker #(
  parameter int IW = scheduler_config::INFLIGHT_WIDTH
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          clr_i,
  output logic [IW-1:0] inflight_o,
  output logic          err_o
`ifdef RUN_STATS_EN
  ,
  output logic [IW-1:0] hwm_o
`endif
);

  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;

  // Next count and error; a step issued and accepted in one cycle cancels out.
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (clr_i) begin
      inflight_d = {IW{1'b0}};
      err_d      = 1'b0;
    end else if (inc_i && dec_i) begin
      inflight_d = inflight_q;
    end else if (inc_i) begin
      inflight_d = inflight_q + IW'(1'b1);
    end else if (dec_i) begin
      if (inflight_q != {IW{1'b0}}) begin
        inflight_d = inflight_q - IW'(1'b1);
      end else begin
        err_d = 1'b1;
      end
    end else begin
      inflight_d = inflight_q;
    end
  end

  // Count and error registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      inflight_q <= {IW{1'b0}};
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight_o = inflight_q;
  assign err_o      = err_q;

`ifdef RUN_STATS_EN
  logic [IW-1:0] hwm_q, hwm_d;

  // High-water mark follows the count it is about to take.
  always_comb begin
    if (clr_i) begin
      hwm_d = {IW{1'b0}};
    end else if (inflight_d > hwm_q) begin
      hwm_d = inflight_d;
    end else begin
      hwm_d = hwm_q;
    end
  end

  // High-water mark register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hwm_q <= {IW{1'b0}};
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm_o = hwm_q;
`endif

endmodule

// File: rtl/network_run_scheduler.sv
// Command-driven sequencer issuing network timesteps paced against the output sink.
// Define RUN_STATS_EN to add the total_steps and max_inflight_seen outputs.
module network_run_scheduler
  import scheduler_config::*;
#(
  parameter  int RUN_WIDTH    = RUN_WIDTH_DEF,
  parameter  int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  localparam int IW           = inflight_width(MAX_INFLIGHT)
) (
  input  logic                   clk,
  input  logic                   arstn,
  network_run_scheduler_if.slave bus,
  output logic                   busy,
  output logic [RUN_WIDTH-1:0]   steps_remaining,
  output logic                   err
`ifdef RUN_STATS_EN
  ,
  output logic [31:0]            total_steps,
  output logic [IW-1:0]          max_inflight_seen
`endif
);

  state_t               state_q, state_d;
  logic [RUN_WIDTH-1:0] rem_q, rem_d;
  logic [IW-1:0]        inflight_s;
  logic                 step_ok_s;
  logic                 step_hs_s;
  logic                 clr_s;

  assign step_ok_s = (state_q == ST_STEP) && (inflight_s < IW'(MAX_INFLIGHT));
  assign step_hs_s = step_ok_s && bus.net_step_ready;
  assign clr_s     = (state_q == ST_CLEAR);

  // Next-state, step countdown and handshake outputs.
  always_comb begin
    state_d            = state_q;
    rem_d              = rem_q;
    bus.cmd_ready      = 1'b0;
    bus.net_step_valid = 1'b0;
    bus.net_clear      = 1'b0;
    bus.sync_valid     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (cmd_op_t'(bus.cmd_op))
            OP_RUN: begin
              if (bus.cmd_arg != {RUN_WIDTH{1'b0}}) begin
                rem_d   = bus.cmd_arg;
                state_d = ST_STEP;
              end else begin
                state_d = ST_IDLE;
              end
            end
            OP_CLR:  state_d = ST_CLEAR;
            OP_SYNC: state_d = ST_SYNC_WAIT;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        bus.net_step_valid = step_ok_s;
        if (step_hs_s) begin
          rem_d = rem_q - RUN_WIDTH'(1'b1);
          if (rem_q == RUN_WIDTH'(1'b1)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STEP;
          end
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_CLEAR: begin
        bus.net_clear = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_SYNC_WAIT: begin
        if (inflight_s == {IW{1'b0}}) begin
          state_d = ST_SYNC_SEND;
        end else begin
          state_d = ST_SYNC_WAIT;
        end
      end
      ST_SYNC_SEND: begin
        bus.sync_valid = 1'b1;
        if (bus.sync_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SYNC_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and step countdown registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      rem_q   <= {RUN_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  inflight_tracker #(
    .IW (IW)
  ) u_tracker (
    .clk        (clk),
    .arstn      (arstn),
    .inc_i      (step_hs_s),
    .dec_i      (bus.out_accept),
    .clr_i      (clr_s),
    .inflight_o (inflight_s),
    .err_o      (err)
`ifdef RUN_STATS_EN
    ,
    .hwm_o      (max_inflight_seen)
`endif
  );

  assign busy            = (state_q != ST_IDLE) || (inflight_s != {IW{1'b0}});
  assign steps_remaining = rem_q;

`ifdef RUN_STATS_EN
  logic [31:0] total_q;

  // Free-running step handshake count, wrapping naturally.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      total_q <= 32'd0;
    end else if (clr_s) begin
      total_q <= 32'd0;
    end else if (step_hs_s) begin
      total_q <= total_q + 32'd1;
    end else begin
      total_q <= total_q;
    end
  end

  assign total_steps = total_q;
`endif

endmodule

// File: tb/tb_network_run_scheduler.sv
// Randomised and directed bench for network_run_scheduler against a cycle-level rule model.
module tb_network_run_scheduler;

  localparam int RW   = 16;
  localparam int MAXI = 2;

  localparam int M_IDLE = 0;
  localparam int M_STEP = 1;
  localparam int M_CLR  = 2;
  localparam int M_WAIT = 3;
  localparam int M_SEND = 4;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  network_run_scheduler_if #(.RUN_WIDTH(RW)) bus ();
  logic          busy;
  logic          err;
  logic [RW-1:0] steps_remaining;
`ifdef RUN_STATS_EN
  logic [31:0]   total_steps;
  logic [1:0]    max_inflight_seen;
`endif

  network_run_scheduler #(.RUN_WIDTH(RW), .MAX_INFLIGHT(MAXI)) dut (
    .clk             (clk),
    .arstn           (arstn),
    .bus             (bus.slave),
    .busy            (busy),
    .steps_remaining (steps_remaining),
    .err             (err)
`ifdef RUN_STATS_EN
    ,
    .total_steps       (total_steps),
    .max_inflight_seen (max_inflight_seen)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_mode, m_rem, m_infl, m_err, m_hwm;
  logic [31:0] m_total;
  int          cyc;
  int          acc_delay;
  int          acc_q[$];
  int          obs_hs, obs_nsv, obs_clr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 50)
        $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_infl = 0; m_err = 0; m_hwm = 0; m_total = 32'd0;
    acc_q.delete();
  endtask

  task automatic check_outputs();
    check_eq("cmd_ready",  32'(bus.cmd_ready),      32'(m_mode == M_IDLE));
    check_eq("step_valid", 32'(bus.net_step_valid), 32'((m_mode == M_STEP) && (m_infl < MAXI)));
    check_eq("net_clear",  32'(bus.net_clear),      32'(m_mode == M_CLR));
    check_eq("sync_valid", 32'(bus.sync_valid),     32'(m_mode == M_SEND));
    check_eq("busy",       32'(busy),               32'((m_mode != M_IDLE) || (m_infl != 0)));
    check_eq("steps_rem",  32'(steps_remaining),    32'(m_rem));
    check_eq("err",        32'(err),                32'(m_err));
`ifdef RUN_STATS_EN
    check_eq("total_steps", total_steps,             m_total);
    check_eq("max_seen",    32'(max_inflight_seen),  32'(m_hwm));
`endif
  endtask

  // Check current outputs, apply one cycle of inputs, advance the model, move to the next negedge.
  task automatic drive_cycle(input logic v, input logic [1:0] op, input int arg,
                             input logic nsr, input logic acc, input logic sr);
    logic hs, a;
    int   nm;
    check_outputs();
    if (bus.net_step_valid && nsr) obs_hs++;
    if (bus.net_step_valid) obs_nsv++;
    if (bus.net_clear) obs_clr++;
    hs = (m_mode == M_STEP) && (m_infl < MAXI) && nsr;
    a  = acc;
    if (acc_q.size() > 0 && acc_q[0] <= cyc) begin
      void'(acc_q.pop_front());
      a = 1'b1;
    end
    if (hs && acc_delay > 0) acc_q.push_back(cyc + acc_delay);
    bus.cmd_valid      = v;
    bus.cmd_op         = op;
    bus.cmd_arg        = arg[RW-1:0];
    bus.net_step_ready = nsr;
    bus.out_accept     = a;
    bus.sync_ready     = sr;
    nm = m_mode;
    case (m_mode)
      M_IDLE: if (v) begin
        if (op == 2'd1 && arg != 0) begin m_rem = arg; nm = M_STEP; end
        else if (op == 2'd2) nm = M_CLR;
        else if (op == 2'd3) nm = M_WAIT;
      end
      M_STEP: if (hs) begin
        if (m_rem == 1) nm = M_IDLE;
        m_rem = m_rem - 1;
      end
      M_CLR:  nm = M_IDLE;
      M_WAIT: if (m_infl == 0) nm = M_SEND;
      M_SEND: if (sr) nm = M_IDLE;
      default: nm = M_IDLE;
    endcase
    if (m_mode == M_CLR) begin
      m_infl = 0; m_err = 0; m_hwm = 0; m_total = 32'd0;
    end else begin
      if (hs) m_total = m_total + 32'd1;
      if (hs && !a) m_infl++;
      else if (!hs && a) begin
        if (m_infl > 0) m_infl--;
        else m_err = 1;
      end
      if (m_infl > m_hwm) m_hwm = m_infl;
    end
    m_mode = nm;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic nsr, input logic sr);
    repeat (n) drive_cycle(1'b0, 2'd0, 0, nsr, 1'b0, sr);
  endtask

  initial begin
    arstn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = '0;
    bus.net_step_ready = 1'b0; bus.out_accept = 1'b0; bus.sync_ready = 1'b0;
    cyc = 0; acc_delay = 0;
    obs_hs = 0; obs_nsv = 0; obs_clr = 0;
    model_reset();
    #3 check_outputs();
    @(negedge clk);
    arstn = 1'b1;

    // RUN 3, sink accepts three cycles after each step
    acc_delay = 3; obs_hs = 0;
    drive_cycle(1'b1, 2'd1, 3, 1'b1, 1'b0, 1'b0);
    idle_cycles(20, 1'b1, 1'b0);
    check_eq("run3_handshakes", 32'(obs_hs), 32'd3);

    // RUN 0 issues nothing
    acc_delay = 0; obs_nsv = 0;
    drive_cycle(1'b1, 2'd1, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(3, 1'b1, 1'b0);
    check_eq("run0_no_step", 32'(obs_nsv), 32'd0);

    // RUN 2 under five cycles of backpressure
    acc_delay = 2;
    drive_cycle(1'b1, 2'd1, 2, 1'b0, 1'b0, 1'b0);
    obs_nsv = 0; obs_hs = 0;
    idle_cycles(5, 1'b0, 1'b0);
    check_eq("bp_valid_held", 32'(obs_nsv), 32'd5);
    check_eq("bp_rem_hold", 32'(steps_remaining), 32'd2);
    idle_cycles(10, 1'b1, 1'b0);
    check_eq("bp_handshakes", 32'(obs_hs), 32'd2);

    // RUN 2 then SYNC with slow sink
    acc_delay = 10;
    drive_cycle(1'b1, 2'd1, 2, 1'b1, 1'b0, 1'b0);
    idle_cycles(2, 1'b1, 1'b0);
    drive_cycle(1'b1, 2'd3, 0, 1'b0, 1'b0, 1'b0);
    idle_cycles(16, 1'b0, 1'b0);
    check_eq("sync_pending", 32'(bus.sync_valid), 32'd1);
    idle_cycles(2, 1'b0, 1'b1);
    check_eq("sync_done_ready", 32'(bus.cmd_ready), 32'd1);

    // Stray accept sets err; CLR pulses net_clear once and clears err
    acc_delay = 0;
    drive_cycle(1'b0, 2'd0, 0, 1'b0, 1'b1, 1'b0);
    idle_cycles(1, 1'b0, 1'b0);
    check_eq("err_set", 32'(err), 32'd1);
    obs_clr = 0;
    drive_cycle(1'b1, 2'd2, 0, 1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b0, 1'b0);
    check_eq("clr_pulse_cnt", 32'(obs_clr), 32'd1);
    check_eq("err_cleared", 32'(err), 32'd0);

    // Asynchronous reset in the middle of a RUN
    drive_cycle(1'b1, 2'd1, 5, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0, 1'b0);
    check_eq("pre_rst_rem", 32'(steps_remaining), 32'd5);
    #2 arstn = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    arstn = 1'b1;
    obs_clr = 0;
    idle_cycles(4, 1'b1, 1'b0);
    check_eq("no_clr_after_rst", 32'(obs_clr), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, nsr, acc, sr;
      logic [1:0] op;
      int arg;
      if (i % 500 == 0) acc_delay = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
      v   = ($urandom_range(0, 1) == 1);
      op  = 2'($urandom_range(0, 3));
      arg = int'($urandom_range(0, 7));
      nsr = ($urandom_range(0, 3) != 0);
      acc = (acc_delay == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      sr  = ($urandom_range(0, 1) == 1);
      drive_cycle(v, op, arg, nsr, acc, sr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/network_run_scheduler.md
Name: network_run_scheduler

Overview:
- Command-driven sequencer that advances the spiking network one timestep at a time and paces it against the output sink.
- Accepts RUN/CLR/SYNC commands from the host-side dispatch decoder and issues step requests to the network.
- Tracks timesteps whose outputs the sink has not yet accepted.
- Emits a SYNC token on the response path once every prior step has drained through the sink.

Parameters:
- RUN_WIDTH, 16, width of the RUN step-count argument and of steps_remaining.
- MAX_INFLIGHT, 2, maximum issued steps not yet accepted by the sink; must be >= 1.

Ports:
- clk  in  1  system clock.
- arstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  scheduler accepts a command this cycle.
- cmd_op  in  2  command code: 0 NOP, 1 RUN, 2 CLR, 3 SYNC.
- cmd_arg  in  RUN_WIDTH  RUN step count; ignored for other ops.
- net_step_valid  out  1  request one network timestep.
- net_step_ready  in  1  network takes the step.
- net_clear  out  1  one-cycle network state clear pulse.
- out_accept  in  1  one-cycle pulse when the sink accepts one timestep's outputs (sink net_valid and net_ready both high).
- sync_valid  out  1  SYNC token pending.
- sync_ready  in  1  response path takes the token.
- busy  out  1  state is not IDLE, or inflight is not 0.
- steps_remaining  out  RUN_WIDTH  steps still to issue in the current RUN.
- err  out  1  sticky flag: out_accept arrived with nothing in flight.

Behaviour:
- Reset values:
  - state IDLE; inflight 0; steps_remaining 0.
  - net_step_valid, net_clear, sync_valid, err, busy all 0.
  - cmd_ready 1.
- States: IDLE, STEP, CLEAR, SYNC_WAIT, SYNC_SEND.
- Command acceptance: cmd_ready = (state == IDLE); a command is accepted on the cycle cmd_valid && cmd_ready.
- IDLE transitions on an accepted command:
  - NOP: stay in IDLE.
  - RUN with cmd_arg = 0: stay in IDLE; nothing is issued.
  - RUN with cmd_arg > 0: load steps_remaining = cmd_arg; go to STEP next cycle.
  - CLR: go to CLEAR.
  - SYNC: go to SYNC_WAIT.
- STEP:
  - net_step_valid = (inflight < MAX_INFLIGHT).
  - On handshake (net_step_valid && net_step_ready): steps_remaining decrements and inflight increments.
  - When steps_remaining goes 1 to 0, return to IDLE on the next cycle; earlier steps may still be in flight.
  - net_step_valid stays high under backpressure until the handshake; steps_remaining holds.
- CLEAR:
  - net_clear high for exactly one cycle.
  - In the same cycle: inflight <= 0, err <= 0.
  - Next state IDLE. Any in-flight sink outputs are the sink's responsibility.
- SYNC_WAIT: wait while inflight != 0; go to SYNC_SEND the cycle after inflight reads 0.
- SYNC_SEND: sync_valid held high until sync_ready; then return to IDLE.
- inflight counter, width $clog2(MAX_INFLIGHT+1), updated in every state:
  - Step handshake and out_accept in the same cycle: inflight unchanged.
  - out_accept alone with inflight > 0: decrement.
  - out_accept with inflight = 0: inflight stays 0 and err <= 1.
- busy is combinational from state and inflight.
- Reset asserted mid-operation: everything returns to reset values asynchronously. No net_clear pulse is generated.

Optional Feature:
- Macro: RUN_STATS_EN.
- Defined:
  - Adds output total_steps, 32 bits, counting every step handshake. Wraps at 2^32.
  - Adds output max_inflight_seen, same width as inflight, recording the high-water mark of inflight.
  - Both reset to 0 and clear in the CLEAR state.
- Undefined: neither port nor their registers exist; all other behaviour is identical.

Decomposition:
- Package scheduler_config holds:
  - cmd_op_t enum (NOP/RUN/CLR/SYNC).
  - state_t enum.
  - Defaults for RUN_WIDTH and MAX_INFLIGHT.
  - INFLIGHT_WIDTH = $clog2(MAX_INFLIGHT+1).
- Sub-module inflight_tracker: the up/down inflight counter with err generation and the optional high-water mark, instantiated once.

Test Plan:
- RUN 3; net_step_ready = 1; out_accept 3 cycles after each handshake; MAX_INFLIGHT = 2 -> 3 handshakes; steps_remaining 3→2→1→0; inflight never exceeds 2; busy falls after the 3rd accept.
- RUN 0 -> cmd_ready stays 1; no net_step_valid; busy stays 0.
- RUN 2 with net_step_ready low for 5 cycles -> net_step_valid held 5 cycles; steps_remaining stays 2; 2 handshakes once released.
- RUN 2 then SYNC, accepts delayed 10 cycles -> sync_valid rises only after the 2nd accept; holds until sync_ready; then cmd_ready returns to 1.
- out_accept pulse while idle with inflight 0 -> err = 1; later CLR -> net_clear high exactly 1 cycle; err = 0.
- arstn low during STEP with steps_remaining = 5 -> all outputs at reset values immediately; after release, cmd_ready = 1 and no net_clear.
